// File: rtl/dvi_timing_pkg.sv
// Shared definitions for the DVI timing controller: register map, 640x480 power-up timing
// and the line-fetch FSM state encoding.
package dvi_timing_pkg;

  localparam int unsigned NUM_REGS = 8;

  localparam logic [2:0] ADDR_HTOTAL   = 3'd0;
  localparam logic [2:0] ADDR_HACTIVE  = 3'd1;
  localparam logic [2:0] ADDR_HS_START = 3'd2;
  localparam logic [2:0] ADDR_HS_END   = 3'd3;
  localparam logic [2:0] ADDR_VTOTAL   = 3'd4;
  localparam logic [2:0] ADDR_VACTIVE  = 3'd5;
  localparam logic [2:0] ADDR_VS_START = 3'd6;
  localparam logic [2:0] ADDR_VS_END   = 3'd7;

  localparam int unsigned DEF_HTOTAL   = 799;
  localparam int unsigned DEF_HACTIVE  = 640;
  localparam int unsigned DEF_HS_START = 656;
  localparam int unsigned DEF_HS_END   = 752;
  localparam int unsigned DEF_VTOTAL   = 524;
  localparam int unsigned DEF_VACTIVE  = 480;
  localparam int unsigned DEF_VS_START = 490;
  localparam int unsigned DEF_VS_END   = 492;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  // Power-up value of the timing register at a given address.
  function automatic int unsigned default_timing(input logic [2:0] addr);
    case (addr)
      ADDR_HTOTAL:   default_timing = DEF_HTOTAL;
      ADDR_HACTIVE:  default_timing = DEF_HACTIVE;
      ADDR_HS_START: default_timing = DEF_HS_START;
      ADDR_HS_END:   default_timing = DEF_HS_END;
      ADDR_VTOTAL:   default_timing = DEF_VTOTAL;
      ADDR_VACTIVE:  default_timing = DEF_VACTIVE;
      ADDR_VS_START: default_timing = DEF_VS_START;
      default:       default_timing = DEF_VS_END;
    endcase
  endfunction

endpackage

// File: rtl/dvi_line_fetch.sv
// Line-fetch handshake toward the framebuffer DMA: holds one request per active line
// and flags an underrun when an active line starts before the DMA accepted it.
module dvi_line_fetch
  import dvi_timing_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_trigger,
  input  logic i_line_ack,
  input  logic i_line_start,
  output logic o_line_req,
  output logic o_underrun
);

  fetch_state_e r_state;
  logic         r_line_req;
  logic         r_underrun;

  // A new trigger wins over a simultaneous ack so the next line is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FETCH_IDLE;
      r_line_req <= 1'b0;
      r_underrun <= 1'b0;
    end else if (i_clear) begin
      r_state    <= FETCH_IDLE;
      r_line_req <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= (r_state == FETCH_REQ) && i_line_start;
      case (r_state)
        FETCH_IDLE: begin
          if (i_trigger) begin
            r_state    <= FETCH_REQ;
            r_line_req <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (i_trigger) begin
            r_state    <= FETCH_REQ;
            r_line_req <= 1'b1;
          end else if (i_line_ack) begin
            r_state    <= FETCH_IDLE;
            r_line_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= FETCH_IDLE;
          r_line_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_line_req = r_line_req;
  assign o_underrun = r_underrun;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI video timing sequencer: pixel divider, beam counters, programmable sync/window decode
// with frame-synchronous register update, and the per-line DMA fetch request.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CNT_W     = 12,
  parameter bit          HSYNC_NEG = 1'b1,
  parameter bit          VSYNC_NEG = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             reg_wr,
  input  logic [2:0]       reg_addr,
  input  logic [CNT_W-1:0] reg_data,
  input  logic             line_ack,
  output logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             window,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             frame_start,
  output logic             line_req,
  output logic             underrun
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_started;
  logic             r_pix_en;
  logic             r_window;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;
  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic [CNT_W-1:0] r_shadow [NUM_REGS];
  logic [CNT_W-1:0] r_live   [NUM_REGS];

  logic             w_tick;
  logic             w_frame_wrap;
  logic             w_copy;
  logic [CNT_W-1:0] w_hpos_nxt;
  logic [CNT_W-1:0] w_vpos_nxt;
  logic [CNT_W-1:0] w_next_line;
  logic [CNT_W-1:0] w_hactive;
  logic [CNT_W-1:0] w_hs_start;
  logic [CNT_W-1:0] w_hs_end;
  logic [CNT_W-1:0] w_vtotal;
  logic [CNT_W-1:0] w_vactive;
  logic [CNT_W-1:0] w_vs_start;
  logic [CNT_W-1:0] w_vs_end;
  logic             w_win_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_trigger;
  logic             w_line_start;

  // Pixel divider; held at 0 while stopped so restart latency is always CLK_DIV clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (!enable || (r_div == DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = enable && (r_div == DIV_LAST);

  // The first pixel after start shows 0,0; later pixels advance the beam.
  always_comb begin
    w_hpos_nxt   = r_hpos;
    w_vpos_nxt   = r_vpos;
    w_frame_wrap = 1'b0;
    if (r_started) begin
      if (r_hpos >= r_live[ADDR_HTOTAL]) begin
        w_hpos_nxt = '0;
        if (r_vpos >= r_live[ADDR_VTOTAL]) begin
          w_vpos_nxt   = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_vpos_nxt = r_vpos + CNT_W'(1);
        end
      end else begin
        w_hpos_nxt = r_hpos + CNT_W'(1);
      end
    end
  end

  // Decode the pixel being entered with the timing that will be live for it.
  assign w_hactive  = w_frame_wrap ? r_shadow[ADDR_HACTIVE]  : r_live[ADDR_HACTIVE];
  assign w_hs_start = w_frame_wrap ? r_shadow[ADDR_HS_START] : r_live[ADDR_HS_START];
  assign w_hs_end   = w_frame_wrap ? r_shadow[ADDR_HS_END]   : r_live[ADDR_HS_END];
  assign w_vtotal   = w_frame_wrap ? r_shadow[ADDR_VTOTAL]   : r_live[ADDR_VTOTAL];
  assign w_vactive  = w_frame_wrap ? r_shadow[ADDR_VACTIVE]  : r_live[ADDR_VACTIVE];
  assign w_vs_start = w_frame_wrap ? r_shadow[ADDR_VS_START] : r_live[ADDR_VS_START];
  assign w_vs_end   = w_frame_wrap ? r_shadow[ADDR_VS_END]   : r_live[ADDR_VS_END];

  assign w_win_nxt    = (w_hpos_nxt < w_hactive) && (w_vpos_nxt < w_vactive);
  assign w_hs_act     = (w_hpos_nxt >= w_hs_start) && (w_hpos_nxt < w_hs_end);
  assign w_vs_act     = (w_vpos_nxt >= w_vs_start) && (w_vpos_nxt < w_vs_end);
  assign w_next_line  = (w_vpos_nxt >= w_vtotal) ? '0 : w_vpos_nxt + CNT_W'(1);
  assign w_trigger    = w_tick && (w_hpos_nxt == w_hactive) && (w_next_line < w_vactive);
  assign w_line_start = w_tick && (w_hpos_nxt == '0) && w_win_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_started     <= 1'b0;
      r_pix_en      <= 1'b0;
      r_frame_start <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_window      <= 1'b0;
      r_hsync       <= HSYNC_NEG;
      r_vsync       <= VSYNC_NEG;
    end else if (!enable) begin
      r_started     <= 1'b0;
      r_pix_en      <= 1'b0;
      r_frame_start <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_window      <= 1'b0;
      r_hsync       <= HSYNC_NEG;
      r_vsync       <= VSYNC_NEG;
    end else begin
      r_pix_en      <= w_tick;
      r_frame_start <= w_tick && (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
      if (w_tick) begin
        r_started <= 1'b1;
        r_hpos    <= w_hpos_nxt;
        r_vpos    <= w_vpos_nxt;
        r_window  <= w_win_nxt;
        r_hsync   <= w_hs_act ^ HSYNC_NEG;
        r_vsync   <= w_vs_act ^ VSYNC_NEG;
      end
    end
  end

  // Shadow bank takes writes; live bank reloads only at frame wrap or while stopped.
  assign w_copy = !enable || (w_tick && w_frame_wrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[3'(i)] <= CNT_W'(default_timing(3'(i)));
        r_live[3'(i)]   <= CNT_W'(default_timing(3'(i)));
      end
    end else begin
      if (reg_wr) begin
        r_shadow[reg_addr] <= reg_data;
      end
      if (w_copy) begin
        r_live <= r_shadow;
      end
    end
  end

  dvi_line_fetch u_line_fetch (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (!enable),
    .i_trigger    (w_trigger),
    .i_line_ack   (line_ack),
    .i_line_start (w_line_start),
    .o_line_req   (line_req),
    .o_underrun   (underrun)
  );

  assign pix_en      = r_pix_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign window      = r_window;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench for dvi_timing_ctrl: default 640x480 line, stop/restart, a reduced
// 20x10 frame with DMA handshake, and a mid-frame timing change.
module tb_dvi_timing_ctrl;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        reg_wr;
  logic [2:0]  reg_addr;
  logic [11:0] reg_data;
  logic        line_ack;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        window;
  logic [11:0] hpos;
  logic [11:0] vpos;
  logic        frame_start;
  logic        line_req;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  dvi_timing_ctrl #(
    .CLK_DIV   (4),
    .CNT_W     (12),
    .HSYNC_NEG (1'b1),
    .VSYNC_NEG (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .line_ack    (line_ack),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .window      (window),
    .hpos        (hpos),
    .vpos        (vpos),
    .frame_start (frame_start),
    .line_req    (line_req),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; reg_wr = 1'b0; reg_addr = 3'd0; reg_data = 12'd0; line_ack = 1'b0;
    #2 reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (pix_en !== 1'b0) begin n_bad++; $display("FAIL rst_pix_en got=%b exp=0", pix_en); end
    n_cmp++; if (hpos !== 12'd0) begin n_bad++; $display("FAIL rst_hpos got=%0d exp=0", hpos); end
    n_cmp++; if (vpos !== 12'd0) begin n_bad++; $display("FAIL rst_vpos got=%0d exp=0", vpos); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
    n_cmp++; if (window !== 1'b0) begin n_bad++; $display("FAIL rst_window got=%b exp=0", window); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    n_cmp++; if (line_req !== 1'b0) begin n_bad++; $display("FAIL rst_line_req got=%b exp=0", line_req); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    reset_n = 1'b1;
    tick();
  endtask

  // One full default line plus the first pixel of line 1, line_ack held low.
  task automatic test_default_line();
    int eh, ev, hs_low;
    logic e_win, e_hs, e_req, e_und;
    enable = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (pix_en !== 1'b0) begin n_bad++; $display("FAIL def_start_gap clk=%0d got=%b exp=0", c, pix_en); end
    end
    tick();
    n_cmp++; if (pix_en !== 1'b1) begin n_bad++; $display("FAIL def_first_pix got=%b exp=1", pix_en); end
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL def_first_fs got=%b exp=1", frame_start); end
    n_cmp++; if (window !== 1'b1) begin n_bad++; $display("FAIL def_first_win got=%b exp=1", window); end
    n_cmp++; if ({hpos, vpos} !== 24'd0) begin n_bad++; $display("FAIL def_first_pos got=%0d,%0d exp=0,0", hpos, vpos); end
    eh = 0; ev = 0; hs_low = 0;
    for (int n = 1; n <= 800; n++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (c < 4) begin
          n_cmp++; if (pix_en !== 1'b0) begin n_bad++; $display("FAIL def_gap px=%0d clk=%0d got=%b exp=0", n, c, pix_en); end
        end
        if (c == 1) begin
          n_cmp++; if (frame_start !== 1'b0 || underrun !== 1'b0) begin n_bad++; $display("FAIL def_pulse_width px=%0d got fs=%b und=%b exp=0,0", n, frame_start, underrun); end
        end
      end
      if (eh == 799) begin eh = 0; ev = ev + 1; end else eh = eh + 1;
      e_win = (eh < 640) && (ev < 480);
      e_hs  = !((eh >= 656) && (eh < 752));
      e_req = (ev == 1) || (eh >= 640);
      e_und = (eh == 0) && (ev == 1);
      if (ev == 0 && !hsync) hs_low++;
      n_cmp++; if (pix_en !== 1'b1) begin n_bad++; $display("FAIL def_pix px=%0d got=%b exp=1", n, pix_en); end
      n_cmp++; if (hpos !== 12'(eh) || vpos !== 12'(ev)) begin n_bad++; $display("FAIL def_pos px=%0d got=%0d,%0d exp=%0d,%0d", n, hpos, vpos, eh, ev); end
      n_cmp++; if (window !== e_win) begin n_bad++; $display("FAIL def_window h=%0d v=%0d got=%b exp=%b", eh, ev, window, e_win); end
      n_cmp++; if (hsync !== e_hs || vsync !== 1'b1) begin n_bad++; $display("FAIL def_sync h=%0d got hs=%b vs=%b exp hs=%b vs=1", eh, hsync, vsync, e_hs); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL def_fs h=%0d v=%0d got=%b exp=0", eh, ev, frame_start); end
      n_cmp++; if (line_req !== e_req) begin n_bad++; $display("FAIL def_line_req h=%0d v=%0d got=%b exp=%b", eh, ev, line_req, e_req); end
      n_cmp++; if (underrun !== e_und) begin n_bad++; $display("FAIL def_underrun h=%0d v=%0d got=%b exp=%b", eh, ev, underrun, e_und); end
    end
    n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL def_hsync_width got=%0d exp=96", hs_low); end
  endtask

  // Stop mid-line with a request pending, then restart.
  task automatic test_disable_reenable();
    repeat (12) tick();
    n_cmp++; if (hpos !== 12'd3 || window !== 1'b1 || line_req !== 1'b1) begin n_bad++; $display("FAIL dis_pre got h=%0d win=%b req=%b exp 3,1,1", hpos, window, line_req); end
    tick(); tick();
    enable = 1'b0;
    tick();
    n_cmp++; if (hpos !== 12'd0 || vpos !== 12'd0) begin n_bad++; $display("FAIL dis_pos got=%0d,%0d exp=0,0", hpos, vpos); end
    n_cmp++; if (pix_en !== 1'b0 || window !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL dis_strobes got pix=%b win=%b fs=%b exp 0,0,0", pix_en, window, frame_start); end
    n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_bad++; $display("FAIL dis_sync got hs=%b vs=%b exp 1,1", hsync, vsync); end
    n_cmp++; if (line_req !== 1'b0 || underrun !== 1'b0) begin n_bad++; $display("FAIL dis_fetch got req=%b und=%b exp 0,0", line_req, underrun); end
    repeat (3) tick();
    enable = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (pix_en !== 1'b0) begin n_bad++; $display("FAIL ren_gap clk=%0d got=%b exp=0", c, pix_en); end
    end
    tick();
    n_cmp++; if (pix_en !== 1'b1 || frame_start !== 1'b1) begin n_bad++; $display("FAIL ren_first got pix=%b fs=%b exp 1,1", pix_en, frame_start); end
    n_cmp++; if (hpos !== 12'd0 || vpos !== 12'd0 || line_req !== 1'b0) begin n_bad++; $display("FAIL ren_state got h=%0d v=%0d req=%b exp 0,0,0", hpos, vpos, line_req); end
  endtask

  // 20x10 frame: hactive 12, hs 14..17, vactive 6, vs 7..8; DMA acks 3 clks after each request.
  task automatic test_small_frame();
    logic [11:0] vals [8];
    int eh, ev, nl;
    logic trig, ack_now, e_win, e_hs, e_vs, e_fs;
    vals[0] = 12'd19; vals[1] = 12'd12; vals[2] = 12'd14; vals[3] = 12'd17;
    vals[4] = 12'd9;  vals[5] = 12'd6;  vals[6] = 12'd7;  vals[7] = 12'd8;
    enable = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      reg_wr = 1'b1; reg_addr = 3'(a); reg_data = vals[a];
      tick();
    end
    reg_wr = 1'b0;
    tick();
    enable = 1'b1;
    repeat (4) tick();
    eh = 0; ev = 0; ack_now = 1'b0;
    for (int n = 0; n <= 400; n++) begin
      if (n > 0) begin
        for (int c = 1; c <= 4; c++) begin
          tick();
          if (c < 4) begin
            n_cmp++; if (pix_en !== 1'b0) begin n_bad++; $display("FAIL sm_gap px=%0d clk=%0d got=%b exp=0", n, c, pix_en); end
          end
          if (ack_now && c == 3) begin
            n_cmp++; if (line_req !== 1'b1) begin n_bad++; $display("FAIL sm_req_hold px=%0d got=%b exp=1", n, line_req); end
            line_ack = 1'b1;
          end
          if (ack_now && c == 4) begin
            n_cmp++; if (line_req !== 1'b0) begin n_bad++; $display("FAIL sm_req_drop px=%0d got=%b exp=0", n, line_req); end
            line_ack = 1'b0;
          end
        end
        ack_now = 1'b0;
        if (eh == 19) begin eh = 0; ev = (ev == 9) ? 0 : ev + 1; end else eh = eh + 1;
      end
      nl    = (ev == 9) ? 0 : ev + 1;
      trig  = (eh == 12) && (nl < 6);
      e_win = (eh < 12) && (ev < 6);
      e_hs  = !((eh >= 14) && (eh < 17));
      e_vs  = !(ev == 7);
      e_fs  = (eh == 0) && (ev == 0);
      n_cmp++; if (pix_en !== 1'b1) begin n_bad++; $display("FAIL sm_pix px=%0d got=%b exp=1", n, pix_en); end
      n_cmp++; if (hpos !== 12'(eh) || vpos !== 12'(ev)) begin n_bad++; $display("FAIL sm_pos px=%0d got=%0d,%0d exp=%0d,%0d", n, hpos, vpos, eh, ev); end
      n_cmp++; if (window !== e_win) begin n_bad++; $display("FAIL sm_window h=%0d v=%0d got=%b exp=%b", eh, ev, window, e_win); end
      n_cmp++; if (hsync !== e_hs || vsync !== e_vs) begin n_bad++; $display("FAIL sm_sync h=%0d v=%0d got=%b%b exp=%b%b", eh, ev, hsync, vsync, e_hs, e_vs); end
      n_cmp++; if (frame_start !== e_fs) begin n_bad++; $display("FAIL sm_fs h=%0d v=%0d got=%b exp=%b", eh, ev, frame_start, e_fs); end
      n_cmp++; if (line_req !== trig) begin n_bad++; $display("FAIL sm_line_req h=%0d v=%0d got=%b exp=%b", eh, ev, line_req, trig); end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL sm_underrun h=%0d v=%0d got=%b exp=0", eh, ev, underrun); end
      if (trig) ack_now = 1'b1;
    end
  endtask

  // Mid-frame writes (htotal 29, hs_end 5) stay in shadow until the frame wraps.
  task automatic test_htotal_change();
    int eh, ev, ht, hs_e, nl;
    logic trig, e_hs, e_win;
    line_ack = 1'b1;
    reg_wr = 1'b1; reg_addr = 3'd0; reg_data = 12'd29;
    eh = 0; ev = 0; ht = 19; hs_e = 17; trig = 1'b0;
    for (int n = 1; n <= 240; n++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (n == 1 && c == 1) begin reg_addr = 3'd3; reg_data = 12'd5; end
        if (n == 1 && c == 2) reg_wr = 1'b0;
        if (trig && c == 1) begin
          n_cmp++; if (line_req !== 1'b0) begin n_bad++; $display("FAIL hc_req_ack px=%0d got=%b exp=0", n, line_req); end
        end
      end
      if (eh == ht) begin
        eh = 0;
        if (ev == 9) begin ev = 0; ht = 29; hs_e = 5; end else ev = ev + 1;
      end else begin
        eh = eh + 1;
      end
      nl    = (ev == 9) ? 0 : ev + 1;
      trig  = (eh == 12) && (nl < 6);
      e_hs  = !((eh >= 14) && (eh < hs_e));
      e_win = (eh < 12) && (ev < 6);
      n_cmp++; if (hpos !== 12'(eh) || vpos !== 12'(ev)) begin n_bad++; $display("FAIL hc_pos px=%0d got=%0d,%0d exp=%0d,%0d", n, hpos, vpos, eh, ev); end
      n_cmp++; if (hsync !== e_hs || window !== e_win) begin n_bad++; $display("FAIL hc_decode h=%0d v=%0d got hs=%b win=%b exp hs=%b win=%b", eh, ev, hsync, window, e_hs, e_win); end
      n_cmp++; if (frame_start !== ((eh == 0) && (ev == 0))) begin n_bad++; $display("FAIL hc_fs h=%0d v=%0d got=%b", eh, ev, frame_start); end
      n_cmp++; if (line_req !== trig || underrun !== 1'b0) begin n_bad++; $display("FAIL hc_fetch h=%0d v=%0d got req=%b und=%b exp req=%b und=0", eh, ev, line_req, underrun, trig); end
    end
    line_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_disable_reenable();
    test_small_frame();
    test_htotal_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
